pit_counter_p: RTL and testbench
================================

PIT_COUNTER_P -- requirements
Module: pit_counter_p

Interface
REQ-001 SHALL have parameter WIDTH, default 16; counting-element width in bits, a multiple of 8 in the range 8..32.
REQ-002 SHALL have derived localparam BYTES = WIDTH/8; the number of bytes per count transfer.
REQ-003 SHALL have port global_CLK  in  1  system clock; the single clock of the block, rising edge.
REQ-004 SHALL have port RST  in  1  reset; synchronous and active-high.
REQ-005 SHALL have port CLK  in  1  count-clock input, sampled as data on global_CLK.
REQ-006 SHALL have port GATE  in  1  count gate.
REQ-007 SHALL have port ctrl_wr  in  1  one-cycle control-word write strobe.
REQ-008 SHALL have port control_word  in  8  mode field in bits [3:1]; other bits ignored.
REQ-009 SHALL have port WR  in  1  one-cycle count-byte write strobe.
REQ-010 SHALL have port data_in  in  8  count byte.
REQ-011 SHALL have port latch  in  1  one-cycle count-latch command.
REQ-012 SHALL have port RD  in  1  one-cycle read strobe.
REQ-013 SHALL have port data_out  out  8  registered read byte.
REQ-014 SHALL have port OUT  out  1  counter output, registered.
REQ-015 SHALL have port null_count  out  1  high while a written count has not yet been loaded into CE.

Function
REQ-016 SHALL define tick as CLK=1 in the current cycle with CLK=0 in the previous cycle, using one register stage; all counting and loading SHALL occur only on ticks.
REQ-017 SHALL support modes 0, 2 and 3; mode field values 1, 4, 5, 6 and 7 SHALL behave as mode 0.
REQ-018 On ctrl_wr, SHALL store the mode, clear the write and read byte pointers, release any latch, set null_count=1, stop counting, and set OUT=0 for mode 0 or OUT=1 for modes 2 and 3.
REQ-019 On WR, SHALL write data_in into CR byte [ptr], with LSB first, and increment the write pointer; when the last of BYTES bytes is written, the pointer SHALL wrap to 0 and a pending load SHALL be set.
REQ-020 In mode 0, the first-byte WR SHALL force OUT=0 and halt decrementing until the new count is loaded.
REQ-021 SHALL load CE from CR on the first tick after the load becomes pending, clear null_count and the pending flag; a CR value of 0 SHALL mean 2^WIDTH.
REQ-022 Mode 0: each tick with GATE=1 after the load SHALL decrement CE by 1; OUT SHALL go to 1 on the tick on which CE becomes 0 and stay 1 until ctrl_wr or a first-byte WR; CE SHALL wrap from 0 to 2^WIDTH-1 and keep counting.
REQ-023 Mode 2: period of N ticks; OUT=0 for exactly the one tick period in which CE=1, 1 otherwise; the following tick SHALL reload CE from CR.
REQ-024 Mode 3: period of N ticks; OUT=1 for ceil(N/2) tick periods and OUT=0 for floor(N/2) tick periods.
REQ-025 Modes 2 and 3: GATE=0 SHALL hold CE and force OUT=1; a GATE 0->1 transition SHALL cause a reload from CR on the next tick.
REQ-026 Modes 2 and 3: N=1 SHALL behave as N=2.
REQ-027 A count written during counting in modes 2 and 3 SHALL take effect only at the next reload, not immediately.
REQ-028 OUT changes SHALL appear on the global_CLK edge that samples the tick, giving one cycle of latency after the CLK rising edge is sampled.
REQ-029 On latch, if no latch is held, SHALL copy CE into OL and mark it held; a latch while already held SHALL be ignored.
REQ-030 On RD, SHALL register into data_out byte [rptr] of OL if held, otherwise of the live CE, then increment rptr; after BYTES reads rptr SHALL wrap to 0 and the held latch SHALL be released.
REQ-031 data_out SHALL hold its value in cycles without RD.
REQ-032 For ctrl_wr with WR in the same cycle, ctrl_wr SHALL win and WR SHALL be ignored.
REQ-033 For latch with RD in the same cycle, the latch SHALL capture CE and the RD SHALL return byte [rptr] of that captured value.
REQ-034 For WR with a load-tick in the same cycle, the load SHALL use the CR value before the write.

Reset
REQ-035 On RST=1 at a global_CLK edge, SHALL set mode 0, CR=0, CE=0, OL=0, both byte pointers 0, latch released, pending load cleared, counting stopped, OUT=0, null_count=1, data_out=0 and the CLK history register to 0.
REQ-036 RST mid-count SHALL abandon any partial byte sequence.
REQ-037 RST SHALL take priority over all strobes in the same cycle.

Verification
REQ-038 Mode 0 single shot: WIDTH=16, ctrl_wr mode 0, WR 0x05 then 0x00, GATE=1 -> null_count clears on tick 1, and OUT rises on tick 6 counting from the load tick.
REQ-039 Mode 2 rate generator: N=4 -> OUT low for 1 tick period in every 4, repeating; GATE pulsed low -> OUT=1, and a reload occurs on the next tick after GATE rises.
REQ-040 Mode 3 square wave: N=5 -> OUT high 3 / low 2 tick periods; N=4 -> OUT high 2 / low 2 tick periods.
REQ-041 Latch and read: latch at CE=0x1234, further ticks, RD, RD -> data_out=0x34 then 0x12; the next RD returns the live CE LSB.
REQ-042 Strobe collision and reset: ctrl_wr and WR in the same cycle -> write pointer 0 and CR unchanged; RST during counting -> all outputs at their reset values on the next cycle.
REQ-043 WIDTH=32, count 0 -> CE loads 2^32 and OUT rises after exactly 2^32 ticks; for simulation speed, check at WIDTH=8 that OUT rises after 256 ticks.

Source files
------------

// File: rtl/pit_counter_p.sv
// Programmable interval timer counter: mode 0 single shot, mode 2 rate generator and mode 3
// square wave, with byte-wide count writes, count latching and byte-sequenced reads.
module pit_counter_p #(
    parameter int WIDTH = 16
) (
    input  logic       global_CLK,
    input  logic       RST,
    input  logic       CLK,
    input  logic       GATE,
    input  logic       ctrl_wr,
    input  logic [7:0] control_word,
    input  logic       WR,
    input  logic [7:0] data_in,
    input  logic       latch,
    input  logic       RD,
    output logic [7:0] data_out,
    output logic       OUT,
    output logic       null_count
);

    localparam int BYTES = WIDTH / 8;
    localparam int PW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } mode_t;

    function automatic mode_t decode_mode(input logic [2:0] f);
        case (f)
            3'd2:    return MODE2;
            3'd3:    return MODE3;
            default: return MODE0;
        endcase
    endfunction

    // A counting-element value of zero stands for 2^WIDTH.
    function automatic logic [WIDTH:0] ce_ext(input logic [WIDTH-1:0] v);
        return (v == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, v};
    endfunction

    function automatic logic periodic_out(input mode_t m, input logic [WIDTH-1:0] ce,
                                          input logic [WIDTH-1:0] half);
        if (m == MODE2) return ce != ONE;
        return ce_ext(ce) > {1'b0, half};
    endfunction

    mode_t            r_mode;
    logic [WIDTH-1:0] r_cr, r_ce, r_ol, r_half;
    logic [PW-1:0]    r_wptr, r_rptr;
    logic             r_clk_d, r_gate_d, r_held, r_pend, r_run, r_trig;
    logic             r_out, r_null;
    logic [7:0]       r_data_out;

    logic             w_tick, w_trig, w_unused;
    logic [WIDTH-1:0] w_n, w_half, w_cr_wr, w_rd_src;
    logic [7:0]       w_rd_byte;
    logic [WIDTH-1:0] w_ce_nxt, w_half_nxt;
    logic             w_out_nxt, w_run_nxt, w_pend_nxt, w_null_nxt, w_trig_nxt;

    assign w_unused = ^{control_word[7:4], control_word[0]};
    assign w_tick   = CLK & ~r_clk_d;
    assign w_trig   = r_trig | (GATE & ~r_gate_d);
    assign w_n      = (r_mode != MODE0 && r_cr == ONE) ? TWO : r_cr;
    assign w_half   = (w_n == '0) ? {1'b1, {(WIDTH-1){1'b0}}} : (w_n >> 1);
    assign w_rd_src = r_held ? r_ol : r_ce;

    always_comb begin
        w_cr_wr   = r_cr;
        w_rd_byte = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (r_wptr == PW'(b)) w_cr_wr[b*8 +: 8] = data_in;
            if (r_rptr == PW'(b)) w_rd_byte = w_rd_src[b*8 +: 8];
        end
    end

    // Counting engine: everything here advances only on a sampled CLK rising edge.
    always_comb begin
        w_ce_nxt   = r_ce;
        w_half_nxt = r_half;
        w_out_nxt  = r_out;
        w_run_nxt  = r_run;
        w_pend_nxt = r_pend;
        w_null_nxt = r_null;
        w_trig_nxt = w_trig;
        if (w_tick && r_pend && !r_run) begin
            w_ce_nxt   = w_n;
            w_half_nxt = w_half;
            w_run_nxt  = 1'b1;
            w_pend_nxt = 1'b0;
            w_null_nxt = 1'b0;
            w_trig_nxt = 1'b0;
            w_out_nxt  = (r_mode == MODE0) ? 1'b0 : periodic_out(r_mode, w_n, w_half);
        end else if (w_tick && r_run && GATE) begin
            if (r_mode == MODE0) begin
                w_ce_nxt = r_ce - ONE;
                if (r_ce == ONE) w_out_nxt = 1'b1;
            end else begin
                // Periodic modes pick up a newly written count only at a reload.
                if (w_trig || r_ce == ONE) begin
                    w_ce_nxt   = w_n;
                    w_half_nxt = w_half;
                    w_trig_nxt = 1'b0;
                    if (r_pend) begin
                        w_pend_nxt = 1'b0;
                        w_null_nxt = 1'b0;
                    end
                end else begin
                    w_ce_nxt = r_ce - ONE;
                end
                w_out_nxt = periodic_out(r_mode, w_ce_nxt, w_half_nxt);
            end
        end
        if (r_mode != MODE0 && !GATE) w_out_nxt = 1'b1;
    end

    always_ff @(posedge global_CLK) begin
        if (RST) begin
            r_mode     <= MODE0;
            r_cr       <= '0;
            r_ce       <= '0;
            r_ol       <= '0;
            r_half     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_clk_d    <= 1'b0;
            r_gate_d   <= 1'b0;
            r_held     <= 1'b0;
            r_pend     <= 1'b0;
            r_run      <= 1'b0;
            r_trig     <= 1'b0;
            r_out      <= 1'b0;
            r_null     <= 1'b1;
            r_data_out <= '0;
        end else begin
            r_clk_d  <= CLK;
            r_gate_d <= GATE;
            r_ce     <= w_ce_nxt;
            r_half   <= w_half_nxt;
            r_out    <= w_out_nxt;
            r_run    <= w_run_nxt;
            r_pend   <= w_pend_nxt;
            r_null   <= w_null_nxt;
            r_trig   <= w_trig_nxt;
            if (latch && !r_held) begin
                r_ol   <= r_ce;
                r_held <= 1'b1;
            end
            if (RD) begin
                r_data_out <= w_rd_byte;
                if (r_rptr == PW'(BYTES-1)) begin
                    r_rptr <= '0;
                    r_held <= 1'b0;
                end else begin
                    r_rptr <= r_rptr + PW'(1);
                end
            end
            if (ctrl_wr) begin
                r_mode <= decode_mode(control_word[3:1]);
                r_wptr <= '0;
                r_rptr <= '0;
                r_held <= 1'b0;
                r_null <= 1'b1;
                r_run  <= 1'b0;
                r_pend <= 1'b0;
                r_trig <= 1'b0;
                r_out  <= (decode_mode(control_word[3:1]) != MODE0);
            end else if (WR) begin
                r_cr   <= w_cr_wr;
                r_null <= 1'b1;
                if (r_wptr == PW'(BYTES-1)) begin
                    r_wptr <= '0;
                    r_pend <= 1'b1;
                end else begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (r_mode == MODE0 && r_wptr == '0) begin
                    r_run <= 1'b0;
                    r_out <= 1'b0;
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign OUT        = r_out;
    assign null_count = r_null;

endmodule

// File: tb/tb_pit_counter_p.sv
// Scoreboard bench for pit_counter_p: a WIDTH=16 instance for the main behaviour and a
// WIDTH=8 instance sharing the same inputs for the full-range terminal count.
module tb_pit_counter_p;

    logic       global_CLK = 1'b0;
    logic       RST = 1'b0, CLK = 1'b0, GATE = 1'b0, ctrl_wr = 1'b0, WR = 1'b0;
    logic       latch = 1'b0, RD = 1'b0;
    logic [7:0] control_word = '0, data_in = '0;
    logic [7:0] data_out, data_out8;
    logic       OUT, null_count, OUT8, null8;

    always #5 global_CLK = ~global_CLK;

    pit_counter_p #(.WIDTH(16)) dut (
        .global_CLK(global_CLK), .RST(RST), .CLK(CLK), .GATE(GATE),
        .ctrl_wr(ctrl_wr), .control_word(control_word), .WR(WR), .data_in(data_in),
        .latch(latch), .RD(RD), .data_out(data_out), .OUT(OUT), .null_count(null_count)
    );

    pit_counter_p #(.WIDTH(8)) dut8 (
        .global_CLK(global_CLK), .RST(RST), .CLK(CLK), .GATE(GATE),
        .ctrl_wr(ctrl_wr), .control_word(control_word), .WR(WR), .data_in(data_in),
        .latch(latch), .RD(RD), .data_out(data_out8), .OUT(OUT8), .null_count(null8)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    localparam int S_OUT = 0, S_NULL = 1, S_DOUT = 2, S_OUT8 = 3, S_NULL8 = 4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_OUT:   return {31'd0, OUT};
            S_NULL:  return {31'd0, null_count};
            S_DOUT:  return {24'd0, data_out};
            S_OUT8:  return {31'd0, OUT8};
            default: return {31'd0, null8};
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic cyc();
        @(negedge global_CLK);
    endtask

    task automatic do_tick();
        CLK = 1'b1;
        cyc();
        CLK = 1'b0;
        cyc();
    endtask

    task automatic ctrl(input logic [7:0] cw);
        control_word = cw;
        ctrl_wr = 1'b1;
        cyc();
        ctrl_wr = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        data_in = d;
        WR = 1'b1;
        cyc();
        WR = 1'b0;
    endtask

    task automatic rd();
        RD = 1'b1;
        cyc();
        RD = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
    endtask

    // Each tick pushes the expected OUT level, drives the tick and compares.
    task automatic tick_expect(input string tag, input logic exp_out);
        expect_val(tag, S_OUT, {31'd0, exp_out});
        do_tick();
        drain();
    endtask

    initial begin
        cyc();

        // Reset values
        expect_val("rst_out", S_OUT, 0);
        expect_val("rst_null", S_NULL, 1);
        expect_val("rst_dout", S_DOUT, 0);
        do_reset();
        drain();

        // Mode 0 single shot, count 5
        ctrl(8'h30);
        expect_val("m0_ctrl_out", S_OUT, 0);
        drain();
        wr(8'h05);
        wr(8'h00);
        GATE = 1'b1;
        cyc();
        expect_val("m0_null_pending", S_NULL, 1);
        drain();
        for (int k = 1; k <= 7; k++) begin
            if (k == 1) expect_val("m0_null_loaded", S_NULL, 0);
            tick_expect("m0_out", k >= 6);
        end

        // Mode 2 rate generator, N=4, with gate pulses
        ctrl(8'h34);
        expect_val("m2_ctrl_out", S_OUT, 1);
        drain();
        wr(8'h04);
        wr(8'h00);
        for (int k = 1; k <= 12; k++) tick_expect("m2_out", ((k - 1) % 4) != 3);
        GATE = 1'b0;
        expect_val("m2_gate_force", S_OUT, 1);
        cyc();
        drain();
        for (int k = 0; k < 2; k++) tick_expect("m2_gate_hold", 1'b1);
        GATE = 1'b1;
        cyc();
        tick_expect("m2_a1", 1'b1);
        tick_expect("m2_a2", 1'b1);
        GATE = 1'b0;
        cyc();
        for (int k = 0; k < 2; k++) tick_expect("m2_gate_hold2", 1'b1);
        GATE = 1'b1;
        cyc();
        for (int k = 1; k <= 5; k++) tick_expect("m2_retrig", k != 4);

        // Mode 2, N=1 runs as N=2
        ctrl(8'h34);
        wr(8'h01);
        wr(8'h00);
        for (int k = 1; k <= 6; k++) tick_expect("m2_n1", ((k - 1) % 2) != 1);

        // Mode 3 square wave, N=5 then N=4 with a mid-period rewrite to N=2
        ctrl(8'h36);
        expect_val("m3_ctrl_out", S_OUT, 1);
        drain();
        wr(8'h05);
        wr(8'h00);
        for (int k = 1; k <= 10; k++) tick_expect("m3_n5", ((k - 1) % 5) < 3);
        ctrl(8'h36);
        wr(8'h04);
        wr(8'h00);
        for (int k = 1; k <= 6; k++) tick_expect("m3_n4", ((k - 1) % 4) < 2);
        wr(8'h02);
        wr(8'h00);
        expect_val("m3_null_rewrite", S_NULL, 1);
        drain();
        tick_expect("m3_old_period7", 1'b0);
        tick_expect("m3_old_period8", 1'b0);
        expect_val("m3_null_reload", S_NULL, 0);
        tick_expect("m3_new_period9", 1'b1);
        tick_expect("m3_new_period10", 1'b0);
        tick_expect("m3_new_period11", 1'b1);

        // Latch and read, mode 0 count 0x1236
        ctrl(8'h30);
        wr(8'h36);
        wr(8'h12);
        for (int k = 0; k < 3; k++) do_tick();
        latch = 1'b1;
        cyc();
        latch = 1'b0;
        do_tick();
        do_tick();
        latch = 1'b1;
        cyc();
        latch = 1'b0;
        do_tick();
        expect_val("rd_latched_lsb", S_DOUT, 32'h34);
        rd();
        drain();
        expect_val("rd_latched_msb", S_DOUT, 32'h12);
        rd();
        drain();
        expect_val("rd_live_lsb", S_DOUT, 32'h31);
        rd();
        drain();
        expect_val("rd_live_msb", S_DOUT, 32'h12);
        rd();
        drain();
        do_tick();
        latch = 1'b1;
        RD = 1'b1;
        expect_val("rd_latch_same_cycle", S_DOUT, 32'h30);
        cyc();
        latch = 1'b0;
        RD = 1'b0;
        drain();
        do_tick();
        expect_val("rd_latch2_msb", S_DOUT, 32'h12);
        rd();
        drain();
        expect_val("rd_released_lsb", S_DOUT, 32'h2F);
        rd();
        drain();
        cyc();
        expect_val("rd_hold", S_DOUT, 32'h2F);
        drain();

        // ctrl_wr and WR together: the write is dropped
        control_word = 8'h30;
        data_in = 8'h77;
        ctrl_wr = 1'b1;
        WR = 1'b1;
        cyc();
        ctrl_wr = 1'b0;
        WR = 1'b0;
        wr(8'h02);
        wr(8'h00);
        for (int k = 1; k <= 3; k++) tick_expect("collide_out", k >= 3);

        // Reset during mode 3 counting
        ctrl(8'h36);
        wr(8'h04);
        wr(8'h00);
        do_tick();
        do_tick();
        expect_val("m3_run_out", S_OUT, 1);
        expect_val("dout_hold_long", S_DOUT, 32'h2F);
        drain();
        expect_val("rst_mid_out", S_OUT, 0);
        expect_val("rst_mid_null", S_NULL, 1);
        expect_val("rst_mid_dout", S_DOUT, 0);
        do_reset();
        drain();

        // Reset abandons a partial byte sequence
        wr(8'h05);
        do_reset();
        wr(8'h03);
        wr(8'h00);
        for (int k = 1; k <= 4; k++) begin
            if (k == 1) expect_val("partial_null", S_NULL, 0);
            tick_expect("partial_out", k >= 4);
        end

        // WIDTH=8, count 0 means 256
        do_reset();
        ctrl(8'h30);
        wr(8'h00);
        for (int k = 1; k <= 257; k++) begin
            if (k == 1) begin
                expect_val("w8_null", S_NULL8, 0);
                expect_val("w8_out_load", S_OUT8, 0);
            end
            if (k == 256) expect_val("w8_out_256", S_OUT8, 0);
            if (k == 257) expect_val("w8_out_257", S_OUT8, 1);
            do_tick();
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
